// File: rtl/vga_output_stage.sv
// vga_output_stage: realigns raw sync timing with pixel-source RGB, blanks and
// optionally borders the active area, sets sync polarity, registers the VGA pins
// and counts frames.
module vga_output_stage #(
    parameter int PIPE_DELAY = 2,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter bit HSYNC_NEG  = 1'b1,
    parameter bit VSYNC_NEG  = 1'b1,
    parameter int FRAME_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               display_on_in,
    input  logic [9:0]         hpos_in,
    input  logic [9:0]         vpos_in,
    input  logic [11:0]        rgb_in,
    input  logic               border_en,
    output logic               hsync,
    output logic               vsync,
    output logic [3:0]         VGA_R,
    output logic [3:0]         VGA_G,
    output logic [3:0]         VGA_B,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE - 1);

    // vld marks stages holding real input rather than reset zeros
    typedef struct packed {
        logic       vld;
        logic       hsync;
        logic       vsync;
        logic       disp;
        logic [9:0] hpos;
        logic [9:0] vpos;
    } timing_t;

    timing_t tm_in;
    timing_t d_tm;

    assign tm_in = '{vld: 1'b1, hsync: hsync_in, vsync: vsync_in,
                     disp: display_on_in, hpos: hpos_in, vpos: vpos_in};

    generate
        if (PIPE_DELAY == 0) begin : g_nodly
            assign d_tm = tm_in;
        end else begin : g_dly
            timing_t dly [PIPE_DELAY];

            // Shift timing through PIPE_DELAY stages to match pixel-source latency
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < PIPE_DELAY; i++) dly[i] <= '0;
                end else begin
                    dly[0] <= tm_in;
                    for (int i = 1; i < PIPE_DELAY; i++) dly[i] <= dly[i-1];
                end
            end

            assign d_tm = dly[PIPE_DELAY-1];
        end
    endgenerate

    logic        on_border;
    logic [11:0] rgb_sel;
    logic        prev_vs;
    logic        armed;
    logic        vs_rise;

    // Colour select: blanking beats border, border beats pixel data
    always_comb begin
        on_border = (d_tm.hpos == 10'd0) || (d_tm.hpos == H_LAST) ||
                    (d_tm.vpos == 10'd0) || (d_tm.vpos == V_LAST);
        rgb_sel = rgb_in;
        if (!d_tm.disp)
            rgb_sel = 12'h000;
        else if (border_en && on_border)
            rgb_sel = 12'hFFF;
    end

    // A rise only counts once a genuine low vsync has been seen after reset,
    // so vsync held high across reset release does not fake a frame start.
    assign vs_rise = armed && d_tm.vsync && !prev_vs;

    // Pin register: sync polarity and colour
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync <= HSYNC_NEG;
            vsync <= VSYNC_NEG;
            VGA_R <= '0;
            VGA_G <= '0;
            VGA_B <= '0;
        end else begin
            hsync <= d_tm.hsync ^ HSYNC_NEG;
            vsync <= d_tm.vsync ^ VSYNC_NEG;
            {VGA_R, VGA_G, VGA_B} <= rgb_sel;
        end
    end

    // Frame edge detect and counter
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_vs     <= 1'b0;
            armed       <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            prev_vs     <= d_tm.vsync;
            armed       <= armed | (d_tm.vld & ~d_tm.vsync);
            frame_start <= vs_rise;
            frame_count <= frame_count + FRAME_W'(vs_rise);
        end
    end

endmodule

// File: tb/tb_vga_output_stage.sv
// tb_vga_output_stage: directed vectors with hand-computed expectations.
module tb_vga_output_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b1;
    logic        display_on_in = 1'b1;
    logic [9:0]  hpos_in = 10'd5;
    logic [9:0]  vpos_in = 10'd5;
    logic [11:0] rgb_in = 12'hABC;
    logic        border_en = 1'b0;

    logic        hsync, vsync, frame_start;
    logic [3:0]  VGA_R, VGA_G, VGA_B;
    logic [15:0] frame_count;

    logic        hsync4, vsync4, frame_start4;
    logic [3:0]  r4, g4, b4;
    logic [3:0]  frame_count4;

    int nvec = 0;
    int nerr = 0;
    int fs_cnt = 0;
    int fs_dbl = 0;
    logic prev_fs = 1'b0;

    always #5 clk = ~clk;

    vga_output_stage u_dut (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .display_on_in(display_on_in), .hpos_in(hpos_in), .vpos_in(vpos_in),
        .rgb_in(rgb_in), .border_en(border_en), .hsync(hsync), .vsync(vsync),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .frame_start(frame_start), .frame_count(frame_count)
    );

    vga_output_stage #(.FRAME_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .display_on_in(display_on_in), .hpos_in(hpos_in), .vpos_in(vpos_in),
        .rgb_in(rgb_in), .border_en(border_en), .hsync(hsync4), .vsync(vsync4),
        .VGA_R(r4), .VGA_G(g4), .VGA_B(b4),
        .frame_start(frame_start4), .frame_count(frame_count4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock; sample 1 ns after the edge and tally frame_start pulses
    task automatic tick();
        @(posedge clk);
        #1;
        if (frame_start === 1'b1) fs_cnt++;
        if (frame_start === 1'b1 && prev_fs === 1'b1) fs_dbl++;
        prev_fs = frame_start;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_vs(input int w);
        vsync_in = 1'b1;
        ticks(w);
        vsync_in = 1'b0;
        ticks(4);
    endtask

    function automatic logic [11:0] rgb_out();
        return {VGA_R, VGA_G, VGA_B};
    endfunction

    initial begin
        // T1: reset held with vsync high and colour present
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_hsync", 32'(hsync), 32'd1);
            chk("t1_vsync", 32'(vsync), 32'd1);
            chk("t1_rgb", 32'(rgb_out()), 32'h0);
            chk("t1_fcnt", 32'(frame_count), 32'd0);
            chk("t1_fs", 32'(frame_start), 32'd0);
        end
        fs_cnt = 0;

        // Release with vsync_in still high: black/inactive until the delay line fills
        reset = 1'b0;
        tick();
        chk("rel_rgb1", 32'(rgb_out()), 32'h0);
        chk("rel_vs1", 32'(vsync), 32'd1);
        tick();
        chk("rel_rgb2", 32'(rgb_out()), 32'h0);
        tick();
        chk("rel_rgb3", 32'(rgb_out()), 32'hABC);
        chk("rel_vs3", 32'(vsync), 32'd0);
        ticks(3);
        chk("rel_nofs", 32'(fs_cnt), 32'd0);
        chk("rel_fcnt", 32'(frame_count), 32'd0);

        // T2: latency, display turns on at cycle N
        vsync_in = 1'b0;
        display_on_in = 1'b0;
        hpos_in = 10'd320;
        vpos_in = 10'd240;
        rgb_in = 12'hFFF;
        ticks(5);
        display_on_in = 1'b1;
        tick();
        chk("t2_n", 32'(rgb_out()), 32'h0);
        tick();
        chk("t2_n1", 32'(rgb_out()), 32'h0);
        rgb_in = 12'h5A3;
        tick();
        chk("t2_r", 32'(VGA_R), 32'h5);
        chk("t2_g", 32'(VGA_G), 32'hA);
        chk("t2_b", 32'(VGA_B), 32'h3);

        // hsync polarity: raw high -> pin low after 3 cycles
        hsync_in = 1'b1;
        ticks(2);
        chk("hs_lat", 32'(hsync), 32'd1);
        tick();
        chk("hs_act", 32'(hsync), 32'd0);
        hsync_in = 1'b0;
        ticks(3);
        chk("hs_idle", 32'(hsync), 32'd1);

        // T3: blanking wins over border and colour
        display_on_in = 1'b0;
        hpos_in = 10'd0;
        rgb_in = 12'hFFF;
        border_en = 1'b1;
        ticks(3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_blank", 32'(rgb_out()), 32'h0);
        end

        // T4: border columns/rows
        display_on_in = 1'b1;
        hpos_in = 10'd639;
        vpos_in = 10'd100;
        rgb_in = 12'h123;
        ticks(3);
        chk("t4_h639", 32'(rgb_out()), 32'hFFF);
        hpos_in = 10'd320;
        vpos_in = 10'd240;
        ticks(3);
        chk("t4_mid", 32'(rgb_out()), 32'h123);
        vpos_in = 10'd479;
        ticks(3);
        chk("t4_v479", 32'(rgb_out()), 32'hFFF);
        vpos_in = 10'd480;
        ticks(3);
        chk("t4_v480", 32'(rgb_out()), 32'h123);
        hpos_in = 10'd0;
        vpos_in = 10'd200;
        ticks(3);
        chk("t4_h0", 32'(rgb_out()), 32'hFFF);
        // border_en acts undelayed: one cycle to the pins
        border_en = 1'b0;
        tick();
        chk("t4_ben_off", 32'(rgb_out()), 32'h123);

        // T5: frame pulses of varying width
        fs_cnt = 0;
        fs_dbl = 0;
        pulse_vs(1);
        pulse_vs(2);
        pulse_vs(5);
        chk("t5_fs3", 32'(fs_cnt), 32'd3);
        chk("t5_fcnt3", 32'(frame_count), 32'd3);
        chk("t5_single", 32'(fs_dbl), 32'd0);
        for (int i = 0; i < 14; i++) pulse_vs(1 + (i % 3));
        chk("t5_fcnt17", 32'(frame_count), 32'd17);
        chk("t5_wrap4", 32'(frame_count4), 32'd1);

        // T6: reset mid-frame with vsync_in high
        rgb_in = 12'h456;
        hpos_in = 10'd100;
        vpos_in = 10'd100;
        ticks(3);
        chk("t6_pre", 32'(rgb_out()), 32'h456);
        vsync_in = 1'b1;
        reset = 1'b1;
        ticks(2);
        chk("t6_rst_rgb", 32'(rgb_out()), 32'h0);
        chk("t6_rst_vs", 32'(vsync), 32'd1);
        chk("t6_rst_fcnt", 32'(frame_count), 32'd0);
        fs_cnt = 0;
        reset = 1'b0;
        tick();
        chk("t6_blk1", 32'(rgb_out()), 32'h0);
        tick();
        chk("t6_blk2", 32'(rgb_out()), 32'h0);
        tick();
        chk("t6_vis", 32'(rgb_out()), 32'h456);
        ticks(4);
        chk("t6_nofs", 32'(fs_cnt), 32'd0);
        vsync_in = 1'b0;
        ticks(4);
        chk("t6_nofs_fall", 32'(fs_cnt), 32'd0);
        pulse_vs(2);
        chk("t6_fs1", 32'(fs_cnt), 32'd1);
        chk("t6_fcnt1", 32'(frame_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
